// File: rtl/usrp_dsp_pkg.sv
// Shared DSP definitions: default datapath widths and the integrate-and-dump
// controller state encoding.
package usrp_dsp_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/accum_load.sv
// Registered accumulator with clock enable and synchronous load.
// The next value is also exposed combinationally, so a completing sample can be
// captured into a holding register on the same edge it is accumulated.
module accum_load
  import usrp_dsp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clken,
  input  logic             sload,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] next_sum
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // Compute the load-or-add result and the held accumulator value.
  always_comb begin
    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    next_sum = sload ? data_in : acc_q + data_in;
    acc_d    = clken ? next_sum : acc_q;
  end

  // Accumulator register; the async clear is used only by reset.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/accum_dump_ctrl.sv
// Integrate-and-dump controller: sums N strobed samples into a frame total and
// presents it on a valid/ready holding register, with sticky overrun when an
// unconsumed total is overwritten. Back-to-back frames have no dead cycle.
module accum_dump_ctrl
  import usrp_dsp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] len,
  input  logic             strobe_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_ovr,
  output logic [WIDTH-1:0] sum_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             overrun,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  logic             strobe_en;
  logic             first;
  logic             complete;
  logic [WIDTH-1:0] next_sum;

  // Frame bookkeeping. cnt_q counts samples already in the accumulator, so in
  // ACCUM the incoming strobe completes the frame when cnt_q == len_q; this
  // covers N = 2^CNT_W without a wider counter.
  always_comb begin
    strobe_en = strobe_in && enable;
    first     = strobe_en && (state_q == ST_IDLE);
    complete  = strobe_en && ((state_q == ST_IDLE) ? (len == '0) : (cnt_q == len_q));

    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = first ? len : len_q;

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (complete) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (first) begin
      state_d = ST_ACCUM;
      cnt_d   = CNT_W'(1);
    end else if (strobe_en) begin
      cnt_d   = cnt_q + CNT_W'(1);
    end

    busy_d = (state_d == ST_ACCUM);
  end

  // Output register, handshake and sticky overrun; a completion always wins.
  always_comb begin
    sum_d     = complete ? next_sum : sum_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (complete)                 valid_d = 1'b1;
    else if (valid_q && ready_in) valid_d = 1'b0;

    if (complete && valid_q && !ready_in) overrun_d = 1'b1;
    else if (clear_ovr)                   overrun_d = 1'b0;
  end

  // Shared accumulator: every accepted strobe adds, a frame-start strobe loads.
  accum_load #(
    .WIDTH (WIDTH)
  ) u_accum (
    .clock    (clock),
    .reset    (reset),
    .clken    (strobe_en),
    .sload    (first),
    .data_in  (data_in),
    .next_sum (next_sum)
  );

  // Controller state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      sum_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign sum_out   = sum_q;
  assign valid_out = valid_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_accum_dump_ctrl.sv
// Bench for accum_dump_ctrl: frame totals are predicted when stimulus is
// driven, queued, and compared whenever the consumer accepts sum_out.
module tb_accum_dump_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic [CNT_W-1:0] len;
  logic             strobe_in;
  logic [WIDTH-1:0] data_in;
  logic             clear_ovr;
  logic [WIDTH-1:0] sum_out;
  logic             valid_out;
  logic             ready_in;
  logic             overrun;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clock = ~clock;

  accum_dump_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .len       (len),
    .strobe_in (strobe_in),
    .data_in   (data_in),
    .clear_ovr (clear_ovr),
    .sum_out   (sum_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Queue an expected total; an overwrite replaces the unconsumed one.
  task automatic expect_total(input logic [WIDTH-1:0] v, input bit overwrite);
    if (overwrite) exp_q.delete();
    exp_q.push_back(v);
  endtask

  // Apply one cycle of stimulus; returns 1 time unit after the capturing edge.
  task automatic drive(input logic s, input logic [WIDTH-1:0] d);
    strobe_in = s;
    data_in   = d;
    @(posedge clock);
    #1;
  endtask

  // Consumer side: a handshake at the next edge takes the oldest expected total.
  always @(negedge clock) begin
    if (!reset && valid_out && ready_in) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", WIDTH'(exp_q.size()), 1);
      end else begin
        check("sb_sum", sum_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; len = '0; strobe_in = 1'b0;
    data_in = '0; clear_ovr = 1'b0; ready_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_sum",     sum_out, 0);
    check("rst_valid",   valid_out, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy",    busy, 0);
    reset = 1'b0;
    drive(0, 0);

    // 1: four-sample frame, consumer ready
    enable = 1'b1; len = 3; ready_in = 1'b1;
    drive(1, 1);
    check("t1_busy_rise", busy, 1);
    drive(1, 2);
    drive(1, 3);
    expect_total(10, 0);
    drive(1, 4);
    check("t1_sum",   sum_out, 10);
    check("t1_valid", valid_out, 1);
    check("t1_busy_fall", busy, 0);
    drive(0, 0);
    check("t1_valid_drop", valid_out, 0);

    // 2: single-sample frames back to back
    len = 0;
    expect_total(7, 0);
    drive(1, 7);
    check("t2_sum0", sum_out, 7);
    check("t2_busy", busy, 0);
    expect_total(9, 0);
    drive(1, 9);
    check("t2_sum1",  sum_out, 9);
    check("t2_valid", valid_out, 1);
    drive(0, 0);
    check("t2_valid_drop", valid_out, 0);
    check("t2_overrun", overrun, 0);

    // 3: modulo wrap
    len = 1;
    drive(1, 32'hFFFF_FFFF);
    expect_total(32'h0000_0001, 0);
    drive(1, 32'h0000_0002);
    check("t3_wrap", sum_out, 32'h0000_0001);
    check("t3_overrun", overrun, 0);
    drive(0, 0);

    // 4: overrun with a stalled consumer
    ready_in = 1'b0;
    drive(1, 5);
    expect_total(10, 0);
    drive(1, 5);
    check("t4_sum0", sum_out, 10);
    check("t4_ovr0", overrun, 0);
    drive(0, 0);
    check("t4_hold_valid", valid_out, 1);
    drive(1, 1);
    expect_total(2, 1);
    drive(1, 1);
    check("t4_sum1",  sum_out, 2);
    check("t4_ovr1",  overrun, 1);
    check("t4_valid", valid_out, 1);
    drive(0, 0);
    drive(0, 0);
    check("t4_stable", sum_out, 2);
    clear_ovr = 1'b1;
    drive(0, 0);
    clear_ovr = 1'b0;
    check("t4_clear", overrun, 0);
    check("t4_valid_kept", valid_out, 1);
    ready_in = 1'b1;
    drive(0, 0);
    check("t4_consumed", valid_out, 0);

    // 5: enable drop aborts a partial frame; len change mid-frame is ignored
    len = 3;
    drive(1, 4);
    drive(1, 4);
    check("t5_busy", busy, 1);
    enable = 1'b0;
    drive(1, 100);
    check("t5_abort", busy, 0);
    check("t5_no_valid", valid_out, 0);
    enable = 1'b1;
    drive(1, 1);
    len = 0;
    drive(1, 1);
    check("t5_len_ignored", busy, 1);
    drive(1, 1);
    expect_total(4, 0);
    drive(1, 1);
    check("t5_sum", sum_out, 4);
    expect_total(5, 0);
    drive(1, 5);
    check("t5_new_len", sum_out, 5);
    drive(0, 0);

    // 6: async reset mid-frame with valid and overrun set
    ready_in = 1'b0;
    expect_total(8, 0);
    drive(1, 8);
    expect_total(9, 1);
    drive(1, 9);
    len = 1;
    drive(1, 3);
    check("t6_pre_ovr",  overrun, 1);
    check("t6_pre_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_sum",   sum_out, 0);
    check("t6_rst_valid", valid_out, 0);
    check("t6_rst_ovr",   overrun, 0);
    check("t6_rst_busy",  busy, 0);
    exp_q.delete();
    strobe_in = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ready_in = 1'b1;
    drive(1, 3);
    expect_total(6, 0);
    drive(1, 3);
    check("t6_sum", sum_out, 6);
    drive(0, 0);
    drive(0, 0);

    check("sb_empty", WIDTH'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/accum_dump_ctrl.md
Name: accum_dump_ctrl

Overview:
Integrate-and-dump controller around a shared 32-bit accumulator datapath. It sums N strobed input samples into one frame total, then dumps the total to a holding register with a valid/ready handshake. A new frame starts with no dead cycle. It sits between a decimating front end (CIC/halfband strobe domain) and the downstream packer or register readback, and sequences the accumulator's enable and per-frame reload.

Parameters:
WIDTH, 32, accumulator and data width; arithmetic is modulo 2^WIDTH.
CNT_W, 16, frame-length counter width; maximum frame is 2^CNT_W samples.

Ports:
clock  in  1  system clock; all logic is rising-edge.
reset  in  1  asynchronous, active-high; clears all state.
enable  in  1  run control; low aborts any partial frame.
len  in  CNT_W  frame length minus one (N = len+1); sampled at frame start.
strobe_in  in  1  qualifies data_in, one sample per strobe.
data_in  in  WIDTH  sample to accumulate (two's complement or unsigned; identical bits).
clear_ovr  in  1  single-cycle pulse that clears the overrun flag.
sum_out  out  WIDTH  last completed frame total.
valid_out  out  1  sum_out holds an unconsumed total.
ready_in  in  1  consumer accepts sum_out when valid_out && ready_in.
overrun  out  1  sticky; a total was overwritten before it was consumed.
busy  out  1  frame in progress (at least one sample accumulated, frame not complete).

Behaviour:
- Reset (async assert): acc=0, cnt=0, len_q=0, state=IDLE, sum_out=0, valid_out=0, overrun=0, busy=0. Reset mid-frame discards everything. On reset release, the block starts in IDLE.
- States:
  - IDLE: cnt=0. Moves to ACCUM on strobe_in && enable.
  - ACCUM: 0 < cnt < N.
  - There is no separate DUMP state. The dump happens on the completing strobe.
- Frame start (strobe while cnt==0, enable=1):
  - len_q <= len.
  - acc <= data_in (load, not add; the accumulator is never cleared through an async clear during operation).
  - cnt <= 1.
  - If len==0, the frame completes on this same strobe.
- Accumulate (strobe while ACCUM): acc <= acc + data_in, wrapping modulo 2^WIDTH with no saturation. cnt <= cnt+1.
- Completion (the strobe that brings the count to N):
  - sum_out <= (first ? data_in : acc+data_in).
  - valid_out <= 1 on the next edge, so latency is 1 clock from the Nth strobe.
  - cnt <= 0 and state <= IDLE. The next strobe, even on the very next cycle, starts a new frame.
- No strobe: acc, cnt and state hold. Gaps between strobes are unbounded.
- Handshake:
  - valid_out && ready_in consumes the total; valid_out falls on the next edge unless a completion occurs in the same cycle, in which case valid_out stays 1 with the new sum.
  - sum_out is stable while valid_out && !ready_in, except on overrun.
- Overrun:
  - Completion while valid_out=1 && ready_in=0 sets overrun=1.
  - sum_out is overwritten, newest wins, and valid_out stays 1.
  - overrun clears only on clear_ovr or reset. If set and clear_ovr occur in the same cycle, set wins.
- len change mid-frame: ignored. len_q governs the current frame.
- enable low:
  - The next edge forces cnt=0 and state=IDLE, discarding the partial acc.
  - A strobe in that cycle is ignored.
  - sum_out, valid_out and overrun are unaffected; the handshake keeps working.
  - When enable rises again, the next strobe starts a fresh frame.
- busy = (state==ACCUM), registered.
- Max frame: with len = all ones, N = 2^CNT_W, and cnt needs CNT_W+1 bits or a compare against len_q.

Decomposition:
- Shared package (usrp_dsp_pkg):
  - WIDTH/CNT_W defaults.
  - State encoding constants ST_IDLE and ST_ACCUM.
- Sub-module accum_load: the WIDTH-bit registered accumulator with clken, sload (load data instead of add) and async clear tied to reset. It exposes next_sum combinationally for the completion capture.
- The controller holds the counter, state, output register, handshake and overrun.

Test Plan:
1. len=3, enable=1, ready_in=1; strobes with data 1,2,3,4 on consecutive cycles -> one cycle after the 4th strobe, sum_out=10 and valid_out=1 for one cycle; busy falls the same edge.
2. len=0, strobes 7,9 back-to-back, ready_in=1 -> sum_out=7, then 9, on successive cycles; valid_out high for 2 cycles; overrun=0.
3. len=1, data 0xFFFF_FFFF then 0x0000_0002 -> sum_out=0x0000_0001 (wrap); no flag.
4. len=1, ready_in=0; frames (5,5) then (1,1) -> sum_out=10, then 2 with overrun=1, valid_out stays 1; pulse clear_ovr -> overrun=0; ready_in=1 -> valid_out drops.
5. len=3; after 2 strobes (data 4,4) drop enable one cycle, re-enable, then strobes 1,1,1,1 -> sum_out=4 (partial frame discarded); change len to 0 mid-frame -> no effect until the next frame.
6. Assert reset asynchronously mid-frame with valid_out=1 and overrun=1 -> all outputs 0 immediately; after release, len=1 and strobes 3,3 -> sum_out=6.
